// File: rtl/drv_pwm_mc.sv
// Multi-channel PWM driver with a shared prescaled counter.
// Edge-aligned mode: the counter counts up and wraps.
// Center-aligned mode: the counter counts up, then down.
// Duty writes are double-buffered. They are applied only at the period boundary.
// Handshake: i_val_wr is a single-cycle strobe with no ready, so a write is always accepted.
// A write sampled on a boundary clock stays pending until the next boundary.
module drv_pwm_mc #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_val,
    input  logic                      i_val_wr,
    input  logic [CHANNELS-1:0]       i_en,
    input  logic                      i_mode,
    input  logic [PRESC_W-1:0]        i_presc,
    output logic [CHANNELS-1:0]       o_drv_port,
    output logic                      o_period_end,
    output logic                      o_pending
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [PRESC_W-1:0]        pc;
    logic [PRESC_W-1:0]        presc_r;
    logic                      mode_r;
    logic [WIDTH-1:0]          cnt;
    logic                      dir_down;
    logic [CHANNELS*WIDTH-1:0] act_duty;
    logic [CHANNELS*WIDTH-1:0] pend_duty;
    logic                      pend_flag;

    logic                      tick;
    logic                      boundary;
    logic [WIDTH-1:0]          cnt_nxt;
    logic                      dir_nxt;
    logic [CHANNELS-1:0]       cmp;

    assign tick = (pc == presc_r);

    // Next counter value and direction for one tick; the turn points are never held.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir_down;
        if (!mode_r) begin
            cnt_nxt = cnt + 1'b1;
            dir_nxt = 1'b0;
        end else if (!dir_down) begin
            if (cnt == CNT_MAX) begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_ONE) begin
                dir_nxt = 1'b0;
            end
        end
    end

    assign boundary = tick && (cnt_nxt == CNT_ZERO);

    // Per-channel compare against the counter value currently held.
    always_comb begin
        cmp = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cmp[k] = i_en[k] && (cnt < act_duty[k*WIDTH +: WIDTH]);
        end
    end

    // Prescaler counter: it wraps on each tick, so it restarts at 0 whenever presc_r reloads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    // Main counter and direction.
    // The direction always restarts as up at a boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (tick) begin
            cnt      <= cnt_nxt;
            dir_down <= boundary ? 1'b0 : dir_nxt;
        end
    end

    // At a boundary, load the configuration and any duty set that was already pending.
    // A write on the same clock wins the pending flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_r    <= 1'b0;
            presc_r   <= '0;
            act_duty  <= '0;
            pend_duty <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (boundary) begin
                mode_r  <= i_mode;
                presc_r <= i_presc;
                if (pend_flag) begin
                    act_duty  <= pend_duty;
                    pend_flag <= 1'b0;
                end
            end
            if (i_val_wr) begin
                pend_duty <= i_val;
                pend_flag <= 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drv_port   <= '0;
            o_period_end <= 1'b0;
        end else begin
            o_drv_port   <= cmp;
            o_period_end <= boundary;
        end
    end

    assign o_pending = pend_flag;

endmodule

// File: tb/tb_drv_pwm_mc.sv
// Bench for drv_pwm_mc with WIDTH=4, CHANNELS=2 and PRESC_W=4.
// A phase-based model produces the expected outputs for every clock.
// Directed scenarios add literal expectations on top of the model.
module tb_drv_pwm_mc;

    localparam int W    = 4;
    localparam int C    = 2;
    localparam int PW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic           clk;
    logic           rst_n;
    logic [C*W-1:0] val;
    logic           val_wr;
    logic [C-1:0]   en;
    logic           mode;
    logic [PW-1:0]  presc;
    logic [C-1:0]   drv_port;
    logic           period_end;
    logic           pending;

    int n_checks;
    int n_errors;

    drv_pwm_mc #(.WIDTH(W), .CHANNELS(C), .PRESC_W(PW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_val       (val),
        .i_val_wr    (val_wr),
        .i_en        (en),
        .i_mode      (mode),
        .i_presc     (presc),
        .o_drv_port  (drv_port),
        .o_period_end(period_end),
        .o_pending   (pending)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: the position inside the period is tracked as a phase.
    // The counter value is derived from the phase.
    logic [C+1:0] exp_q[$];
    int           m_phase, m_q, m_presc, m_period, m_cur;
    bit           m_mode, m_flag, m_bnd;
    int           m_act[C];
    int           m_pend[C];
    logic [C-1:0] m_port;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_q = 0; m_presc = 0; m_mode = 0; m_flag = 0;
            for (int k = 0; k < C; k++) begin
                m_act[k]  = 0;
                m_pend[k] = 0;
            end
            exp_q.delete();
        end else begin
            m_period = m_mode ? 2 * MAXV : MAXV + 1;
            m_cur = (m_mode && m_phase > MAXV) ? 2 * MAXV - m_phase : m_phase;
            for (int k = 0; k < C; k++) m_port[k] = en[k] && (m_cur < m_act[k]);
            m_bnd = 0;
            if (m_q == m_presc) begin
                m_q = 0;
                m_phase++;
                if (m_phase == m_period) begin
                    m_phase = 0;
                    m_bnd = 1;
                end
            end else begin
                m_q++;
            end
            if (m_bnd) begin
                if (m_flag) begin
                    for (int k = 0; k < C; k++) m_act[k] = m_pend[k];
                    m_flag = 0;
                end
                m_mode  = mode;
                m_presc = int'(presc);
            end
            if (val_wr) begin
                for (int k = 0; k < C; k++) m_pend[k] = int'(val[k*W +: W]);
                m_flag = 1;
            end
            exp_q.push_back({m_bnd, m_flag, m_port});
        end
    end

    // Compare process: checks every clock away from the active edge.
    always @(negedge clk) begin
        logic [C+1:0] e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", int'({period_end, pending, drv_port}), int'(e));
        end
    end

    // Driver tasks.
    task automatic write_duty(input int d0, input int d1);
        @(negedge clk);
        #1;
        val    = {W'(d1), W'(d0)};
        val_wr = 1'b1;
        @(negedge clk);
        #1;
        val_wr = 1'b0;
    endtask

    task automatic wait_pe(input int budget);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!period_end && i < budget);
        check("period_end_seen", int'(period_end), 1);
    endtask

    task automatic measure(input int n, output int h0, output int h1, output int pe,
                           output logic [63:0] mask);
        h0 = 0; h1 = 0; pe = 0; mask = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h0 += int'(drv_port[0]);
            h1 += int'(drv_port[1]);
            pe += int'(period_end);
            mask[i] = drv_port[0];
        end
    endtask

    initial begin
        int          h0, h1, pe, i;
        logic [63:0] mask;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; val = '0; val_wr = 1'b0; en = '0; mode = 1'b0; presc = '0;
        repeat (3) @(negedge clk);
        check("reset_port", int'(drv_port), 0);
        check("reset_pe", int'(period_end), 0);
        check("reset_pending", int'(pending), 0);
        #1 rst_n = 1'b1;

        // Edge mode, prescaler 0, ch0 = 5, ch1 = 0.
        en = 2'b11;
        write_duty(5, 0);
        wait_pe(40);
        wait_pe(40);
        measure(16, h0, h1, pe, mask);
        check("edge_hi_ch0", h0, 5);
        check("edge_hi_ch1", h1, 0);
        check("edge_pe_per16", pe, 1);

        // Center mode with ch0 = 4: the high window is symmetric about the boundary.
        mode = 1'b1;
        write_duty(4, 0);
        wait_pe(40);
        wait_pe(60);
        measure(30, h0, h1, pe, mask);
        check("center_hi_ch0", h0, 7);
        check("center_pe_per30", pe, 1);
        check("center_shape", int'(mask[29:0]), 32'h3800000F);

        // Prescaler 2 with maximum duty: low for one tick, which lasts 3 clocks.
        mode  = 1'b0;
        presc = 4'd2;
        write_duty(15, 0);
        wait_pe(200);
        wait_pe(200);
        measure(48, h0, h1, pe, mask);
        check("presc_hi_ch0", h0, 45);
        check("presc_pe_per48", pe, 1);

        // Pending overwrite: the last write before the boundary wins.
        presc = 4'd0;
        wait_pe(200);
        repeat (3) @(negedge clk);
        write_duty(8, 0);
        check("pending_after_wr", int'(pending), 1);
        repeat (2) @(negedge clk);
        write_duty(3, 0);
        check("pending_after_wr2", int'(pending), 1);
        wait_pe(40);
        check("pending_cleared", int'(pending), 0);
        wait_pe(40);
        measure(16, h0, h1, pe, mask);
        check("last_write_wins", h0, 3);

        // A write on the boundary clock is applied one period later.
        wait_pe(40);
        repeat (15) @(negedge clk);
        #1;
        val    = {W'(0), W'(6)};
        val_wr = 1'b1;
        @(negedge clk);
        check("bnd_wr_pe", int'(period_end), 1);
        check("bnd_wr_pending", int'(pending), 1);
        #1 val_wr = 1'b0;
        measure(16, h0, h1, pe, mask);
        check("bnd_wr_not_loaded", h0, 3);
        check("bnd_wr_loaded_flag", int'(pending), 0);
        measure(16, h0, h1, pe, mask);
        check("bnd_wr_applied", h0, 6);

        // Dropping the enable forces the output low on the next clock.
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!drv_port[0] && i < 40);
        check("found_high", int'(drv_port[0]), 1);
        #1 en = 2'b10;
        @(negedge clk);
        check("en_drop_low", int'(drv_port[0]), 0);
        repeat (3) @(negedge clk);
        #1 en = 2'b11;
        measure(16, h0, h1, pe, mask);
        check("en_restore_hi", h0, 6);

        // Reset mid-period with a write pending.
        write_duty(9, 9);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_port", int'(drv_port), 0);
        check("async_rst_pe", int'(period_end), 0);
        check("async_rst_pending", int'(pending), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        measure(40, h0, h1, pe, mask);
        check("post_rst_ch0_low", h0, 0);
        check("post_rst_ch1_low", h1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
